// File: rtl/up_down_counter_mod.sv
// -----------------------------------------------------------------------------
// up_down_counter_mod
//
// Parametrised synchronous modulo-N up/down counter with count enable,
// direction select, parallel load (clamped into range) and a registered
// terminal-count pulse. This is the shared counter primitive for dividers,
// timers and address sequencers.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   MOD_VAL  modulus; q ranges over 0..MOD_VAL-1 (2 <= MOD_VAL <= 2**WIDTH)
//   RST_VAL  value placed on q by reset (< MOD_VAL)
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   en        in   1      count enable, one step per edge while high
//   up_dn     in   1      direction: 1 = up, 0 = down
//   load      in   1      synchronous parallel load strobe (beats en)
//   load_val  in   WIDTH  value loaded when load = 1 (clamped to MOD_VAL-1)
//   q         out  WIDTH  current count, registered
//   tc        out  1      terminal-count pulse, registered; high in the cycle
//                         q shows the wrapped value
//
// Build option
//   UP_DOWN_COUNTER_SATURATE_EN  when defined, the counter saturates at the
//   range limits instead of wrapping; tc is raised on every enabled edge that
//   tries to move past a limit. Undefined (default) gives modulo wrap-around.
// -----------------------------------------------------------------------------
module up_down_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MOD_VAL = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Reject parameter sets that would let q leave its range.
    if (WIDTH < 1) begin : g_bad_width
        $error("up_down_counter_mod: WIDTH must be >= 1");
    end
    if (MOD_VAL < 2 || longint'(MOD_VAL) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $error("up_down_counter_mod: MOD_VAL must lie in 2..2**WIDTH");
    end
    if (RST_VAL < 0 || RST_VAL >= MOD_VAL) begin : g_bad_rst
        $error("up_down_counter_mod: RST_VAL must lie in 0..MOD_VAL-1");
    end

    // Range comparisons are done one bit wider than q so that
    // MOD_VAL = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD_VAL);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MOD_VAL - 1);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD_VAL - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             tc_reg;
    logic             tc_next;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   load_ext;

    assign q_ext    = {1'b0, q_reg};
    assign load_ext = {1'b0, load_val};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg  <= RST_Q;
            tc_reg <= 1'b0;
        end else begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    // Priority: load over count enable; with neither, q holds and tc drops.
    always_comb begin
        q_next  = q_reg;
        tc_next = 1'b0;
        if (load) begin
            if (load_ext >= MOD_W) begin
                q_next = MAX_Q;
            end else begin
                q_next = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (q_ext == MAX_W) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                    q_next  = MAX_Q;
`else
                    q_next  = '0;
`endif
                    tc_next = 1'b1;
                end else begin
                    // q < MOD_VAL-1 here, so the increment cannot overflow WIDTH.
                    q_next = q_reg + WIDTH'(1);
                end
            end else begin
                if (q_reg == '0) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
                    q_next  = '0;
`else
                    q_next  = MAX_Q;
`endif
                    tc_next = 1'b1;
                end else begin
                    q_next = q_reg - WIDTH'(1);
                end
            end
        end
    end

    assign q  = q_reg;
    assign tc = tc_reg;

endmodule
